// File: rtl/fft_pkg.sv
// Shared types and helpers for the FFT stage sequencer.
// Holds the FSM encoding and the butterfly address rule.
package fft_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_FLUSH,
    ST_DONE
  } fsm_e;

  localparam int unsigned AW_MAX = 16;

  // Insert a zero bit at position s of b: upper-leg address.
  function automatic logic [AW_MAX-1:0] bit_insert(
    input logic [AW_MAX-1:0] b,
    input int unsigned       s
  );
    logic [AW_MAX-1:0] lo_mask;
    lo_mask = (AW_MAX'(1) << s) - AW_MAX'(1);
    return ((b >> s) << (s + 1)) | (b & lo_mask);
  endfunction

endpackage

// File: rtl/fft_bit_insert.sv
// Butterfly leg addresses from butterfly index b and stage s.
// Purely combinational; the caller registers the result.
module fft_bit_insert
  import fft_pkg::*;
#(
  parameter int MSB = 8,
  parameter int SW  = $clog2(MSB)
) (
  input  logic [MSB-2:0] b_i,
  input  logic [SW-1:0]  s_i,
  output logic [MSB-1:0] addr_a_o,
  output logic [MSB-1:0] addr_b_o
);

  always_comb begin
    addr_a_o = MSB'(bit_insert(AW_MAX'(b_i), 32'(s_i)));
    addr_b_o = addr_a_o | (MSB'(1) << s_i);
  end

endmodule

// File: rtl/fft_stage_sequencer.sv
// Radix-2 FFT stage/butterfly sequencer with flush gaps.
// Emits one registered descriptor per butterfly via valid/ready.
module fft_stage_sequencer
  import fft_pkg::*;
#(
  parameter int MSB        = 8,
  parameter int PIPE_DEPTH = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  output logic                    busy,
  output logic                    done,
  output logic                    op_valid,
  input  logic                    op_ready,
  output logic [MSB-1:0]          addr_a,
  output logic [MSB-1:0]          addr_b,
  output logic [MSB-2:0]          tw_idx,
  output logic [$clog2(MSB)-1:0]  stage
);

  localparam int SW = $clog2(MSB);
  localparam int BW = MSB - 1;
  localparam int FW = (PIPE_DEPTH > 1) ? $clog2(PIPE_DEPTH) : 1;
  localparam logic [SW-1:0] S_LAST = SW'(MSB - 1);
  localparam logic [FW-1:0] F_LAST =
    FW'((PIPE_DEPTH > 0) ? PIPE_DEPTH - 1 : 0);

  fsm_e state_q, state_d;

  logic [SW-1:0]  s_q, s_d;
  logic [BW-1:0]  b_q, b_d;
  logic [FW-1:0]  f_q, f_d;
  logic [MSB-1:0] aa_q, ab_q;
  logic [MSB-1:0] aa_d, ab_d;
  logic [BW-1:0]  tw_q, tw_d;
  logic [BW-1:0]  tw_mask;

  // Descriptor is computed from the next (s, b) so the
  // registered copy lines up with the current (s, b).
  fft_bit_insert #(
    .MSB (MSB),
    .SW  (SW)
  ) u_ins (
    .b_i      (b_d),
    .s_i      (s_d),
    .addr_a_o (aa_d),
    .addr_b_o (ab_d)
  );

  always_comb begin
    tw_mask = (BW'(1) << s_d) - BW'(1);
    tw_d    = (b_d & tw_mask) << (MSB - 1 - int'(s_d));
  end

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    b_d     = b_q;
    f_d     = f_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          s_d     = '0;
          b_d     = '0;
        end
      end
      ST_RUN: begin
        if (op_ready) begin
          b_d = b_q + 1'b1;
          if (b_q == '1) begin
            b_d = '0;
            f_d = '0;
            if (PIPE_DEPTH > 0) begin
              state_d = ST_FLUSH;
            end else if (s_q == S_LAST) begin
              state_d = ST_DONE;
            end else begin
              s_d = s_q + 1'b1;
            end
          end
        end
      end
      ST_FLUSH: begin
        if (f_q == F_LAST) begin
          f_d = '0;
          if (s_q == S_LAST) begin
            state_d = ST_DONE;
          end else begin
            s_d     = s_q + 1'b1;
            state_d = ST_RUN;
          end
        end else begin
          f_d = f_q + 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        s_d     = '0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      s_q     <= '0;
      b_q     <= '0;
      f_q     <= '0;
      aa_q    <= '0;
      ab_q    <= '0;
      tw_q    <= '0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      b_q     <= b_d;
      f_q     <= f_d;
      if (state_d == ST_RUN) begin
        aa_q <= aa_d;
        ab_q <= ab_d;
        tw_q <= tw_d;
      end else begin
        aa_q <= '0;
        ab_q <= '0;
        tw_q <= '0;
      end
    end
  end

  assign busy     = (state_q != ST_IDLE);
  assign done     = (state_q == ST_DONE);
  assign op_valid = (state_q == ST_RUN);
  assign addr_a   = aa_q;
  assign addr_b   = ab_q;
  assign tw_idx   = tw_q;
  assign stage    = s_q;

endmodule

// File: tb/tb_fft_stage_sequencer.sv
// Bench for fft_stage_sequencer: vector table, scoreboard,
// stall, mid-run reset and back-to-back start sequences.
module tb_fft_stage_sequencer;

  localparam int M = 3;
  localparam int N = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  logic         start0, rdy0, busy0, done0, vld0;
  logic [M-1:0] aa0, ab0;
  logic [M-2:0] tw0;
  logic [1:0]   stg0;
  logic         start1, rdy1, busy1, done1, vld1;
  logic [M-1:0] aa1, ab1;
  logic [M-2:0] tw1;
  logic [1:0]   stg1;

  fft_stage_sequencer #(.MSB(M), .PIPE_DEPTH(2)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start0),
    .busy(busy0), .done(done0), .op_valid(vld0),
    .op_ready(rdy0), .addr_a(aa0), .addr_b(ab0),
    .tw_idx(tw0), .stage(stg0)
  );

  fft_stage_sequencer #(.MSB(M), .PIPE_DEPTH(0)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start1),
    .busy(busy1), .done(done1), .op_valid(vld1),
    .op_ready(rdy1), .addr_a(aa1), .addr_b(ab1),
    .tw_idx(tw1), .stage(stg1)
  );

  typedef struct {
    logic st;
    logic busy;
    logic done;
    logic vld;
    int   stg;
    int   a;
    int   b;
    int   tw;
  } vec_t;

  typedef struct {
    int a;
    int b;
    int tw;
    int stg;
  } desc_t;

  vec_t  tbl[21];
  desc_t sb_q[$];

  int total = 0;
  int bad   = 0;
  int hs    = 0;
  int dones = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(logic st, logic bz, logic dn,
                              logic vl, int sg, int a,
                              int b, int tw);
    vec_t v;
    v.st = st; v.busy = bz; v.done = dn; v.vld = vl;
    v.stg = sg; v.a = a; v.b = b; v.tw = tw;
    return v;
  endfunction

  // Arithmetic reference: split b around bit s.
  function automatic desc_t model(int s, int b);
    desc_t d;
    int p;
    p = 1 << s;
    d.a   = (b / p) * (2 * p) + (b % p);
    d.b   = d.a + p;
    d.tw  = ((b % p) * (1 << (M - 1 - s))) % (1 << (M - 1));
    d.stg = s;
    return d;
  endfunction

  task automatic push_all();
    for (int s = 0; s < M; s++)
      for (int b = 0; b < N / 2; b++)
        sb_q.push_back(model(s, b));
  endtask

  task automatic sample();
    desc_t e;
    if (vld0 && rdy0) begin
      hs++;
      if (sb_q.size() == 0) begin
        chk("sb_depth", sb_q.size(), 1);
      end else begin
        e = sb_q.pop_front();
        chk("sb_a", aa0, e.a);
        chk("sb_b", ab0, e.b);
        chk("sb_tw", tw0, e.tw);
        chk("sb_stg", stg0, e.stg);
      end
    end
    if (done0) dones++;
  endtask

  task automatic step();
    @(negedge clk);
    sample();
    @(posedge clk);
    #1;
  endtask

  task automatic run_table();
    int h0, d0;
    h0 = hs;
    d0 = dones;
    rdy0 = 1'b1;
    for (int i = 0; i < 21; i++) begin
      start0 = tbl[i].st;
      if (i == 0) push_all();
      @(negedge clk);
      chk("tb_busy", busy0, tbl[i].busy);
      chk("tb_done", done0, tbl[i].done);
      chk("tb_vld", vld0, tbl[i].vld);
      if (tbl[i].stg >= 0) chk("tb_stg", stg0, tbl[i].stg);
      if (tbl[i].vld) begin
        chk("tb_a", aa0, tbl[i].a);
        chk("tb_b", ab0, tbl[i].b);
        chk("tb_tw", tw0, tbl[i].tw);
      end
      sample();
      @(posedge clk);
      #1;
    end
    start0 = 1'b0;
    @(negedge clk);
    chk("tb_noqueue", busy0, 0);
    @(posedge clk);
    #1;
    chk("tb_hs", hs - h0, 12);
    chk("tb_done_cnt", dones - d0, 1);
    chk("tb_sb_left", sb_q.size(), 0);
  endtask

  initial begin
    int h0, d0, k;

    tbl[0]  = mk(1, 0, 0, 0, -1, 0, 0, 0);
    tbl[1]  = mk(0, 1, 0, 1, 0, 0, 1, 0);
    tbl[2]  = mk(0, 1, 0, 1, 0, 2, 3, 0);
    tbl[3]  = mk(1, 1, 0, 1, 0, 4, 5, 0);
    tbl[4]  = mk(0, 1, 0, 1, 0, 6, 7, 0);
    tbl[5]  = mk(0, 1, 0, 0, 0, 0, 0, 0);
    tbl[6]  = mk(1, 1, 0, 0, 0, 0, 0, 0);
    tbl[7]  = mk(0, 1, 0, 1, 1, 0, 2, 0);
    tbl[8]  = mk(0, 1, 0, 1, 1, 1, 3, 2);
    tbl[9]  = mk(0, 1, 0, 1, 1, 4, 6, 0);
    tbl[10] = mk(0, 1, 0, 1, 1, 5, 7, 2);
    tbl[11] = mk(0, 1, 0, 0, 1, 0, 0, 0);
    tbl[12] = mk(1, 1, 0, 0, 1, 0, 0, 0);
    tbl[13] = mk(0, 1, 0, 1, 2, 0, 4, 0);
    tbl[14] = mk(0, 1, 0, 1, 2, 1, 5, 1);
    tbl[15] = mk(0, 1, 0, 1, 2, 2, 6, 2);
    tbl[16] = mk(0, 1, 0, 1, 2, 3, 7, 3);
    tbl[17] = mk(0, 1, 0, 0, 2, 0, 0, 0);
    tbl[18] = mk(0, 1, 0, 0, 2, 0, 0, 0);
    tbl[19] = mk(1, 1, 1, 0, -1, 0, 0, 0);
    tbl[20] = mk(0, 0, 0, 0, -1, 0, 0, 0);

    rst_n  = 1'b0;
    start0 = 1'b1;
    rdy0   = 1'b1;
    start1 = 1'b0;
    rdy1   = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_busy", busy0, 0);
    chk("rst_done", done0, 0);
    chk("rst_vld", vld0, 0);
    chk("rst_addr", {aa0, ab0, tw0, stg0}, 0);
    chk("rst1_out", {busy1, done1, vld1, aa1, ab1, tw1, stg1}, 0);
    @(posedge clk);
    #1;
    rst_n  = 1'b1;
    start0 = 1'b0;
    step();

    run_table();

    // Backpressure at s1,b2 for three cycles.
    h0 = hs;
    d0 = dones;
    start0 = 1'b1;
    push_all();
    step();
    start0 = 1'b0;
    repeat (8) step();
    rdy0 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_vld", vld0, 1);
      chk("stall_a", aa0, 4);
      chk("stall_b", ab0, 6);
      chk("stall_tw", tw0, 0);
      chk("stall_stg", stg0, 1);
      sample();
      @(posedge clk);
      #1;
    end
    rdy0 = 1'b1;
    k = 0;
    while (k < 60 && dones == d0) begin
      step();
      k++;
    end
    chk("stall_done", dones - d0, 1);
    chk("stall_hs", hs - h0, 12);
    chk("stall_sb_left", sb_q.size(), 0);
    step();

    // Reset in the middle of stage 1.
    start0 = 1'b1;
    push_all();
    step();
    start0 = 1'b0;
    repeat (7) step();
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_stg", stg0, 1);
    chk("mid_a", aa0, 1);
    chk("mid_b", ab0, 3);
    sample();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("mid_rst_out",
        {busy0, done0, vld0, aa0, ab0, tw0, stg0}, 0);
    @(posedge clk);
    #1;
    sb_q.delete();
    d0 = dones;
    repeat (30) step();
    chk("mid_no_done", dones - d0, 0);
    run_table();

    // Start held high, no flush gaps.
    start1 = 1'b1;
    for (int c = 0; c < 17; c++) begin
      @(negedge clk);
      chk("b2b_busy", busy1, !(c == 0 || c == 14));
      chk("b2b_done", done1, c == 13);
      chk("b2b_vld", vld1,
          (c >= 1 && c <= 12) || (c >= 15));
      @(posedge clk);
      #1;
    end
    start1 = 1'b0;
    k = 0;
    while (k < 40 && busy1) begin
      @(posedge clk);
      #1;
      k++;
    end
    @(negedge clk);
    chk("b2b_idle", busy1, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
